// File: rtl/tick_gen_multi.sv
// N-channel programmable tick/toggle generator on clk50, with divisor and control
// registers on the 8-bit I/O bus (4 registers per channel starting at IOBASE).
module tick_gen_multi #(
  parameter int          NCH     = 4,
  parameter int          CW      = 28,
  parameter logic [7:0]  IOBASE  = 8'hE0,
  parameter int unsigned DEF_DIV = 24999999,
  parameter bit          DEF_EN  = 1'b1
) (
  input  logic           clk50,
  input  logic           reset,
  input  logic [7:0]     ioad,
  input  logic [15:0]    iowdt,
  input  logic           iow,
  input  logic           ior,
  output logic [15:0]    iordt,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] sq,
  output logic [NCH-1:0] done
);

  localparam int HW = CW - 16;
  localparam logic [CW-1:0] DEF_DIV_W = CW'(DEF_DIV);

  logic [CW-1:0]  shadow_div [NCH];
  // cycles left before the terminal count; reloaded from shadow_div at terminal/restart
  logic [CW-1:0]  rem        [NCH];
  logic [NCH-1:0] en;
  logic [NCH-1:0] oneshot;

  logic [8:0]     rel;
  logic           hit;
  logic [3:0]     sel_ch;
  logic [1:0]     sel_reg;
  logic [NCH-1:0] wr_lo, wr_hi, wr_ctl;
  logic [15:0]    rd_val;

  always_comb begin
    rel     = {1'b0, ioad} - {1'b0, IOBASE};
    hit     = (ioad >= IOBASE) && (rel < 9'(4 * NCH));
    sel_ch  = rel[5:2];
    sel_reg = rel[1:0];
    wr_lo   = '0;
    wr_hi   = '0;
    wr_ctl  = '0;
    rd_val  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (hit && sel_ch == 4'(c)) begin
        wr_lo[c]  = iow && (sel_reg == 2'd0);
        wr_hi[c]  = iow && (sel_reg == 2'd1);
        wr_ctl[c] = iow && (sel_reg == 2'd2);
        case (sel_reg)
          2'd0:    rd_val = shadow_div[c][15:0];
          2'd1:    rd_val = 16'(shadow_div[c][CW-1:16]);
          2'd2:    rd_val = {14'd0, oneshot[c], en[c]};
          default: rd_val = {13'd0, sq[c], done[c], en[c]};
        endcase
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      iordt <= '0;
    end else if (ior && hit) begin
      iordt <= rd_val;
    end else begin
      iordt <= '0;
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        shadow_div[c] <= DEF_DIV_W;
        rem[c]        <= DEF_DIV_W;
      end
      en      <= {NCH{DEF_EN}};
      oneshot <= '0;
      tick    <= '0;
      sq      <= '0;
      done    <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        tick[c] <= 1'b0;
        // a restart overrides a terminal count landing in the same cycle
        if (wr_ctl[c] && iowdt[2]) begin
          rem[c]  <= shadow_div[c];
          sq[c]   <= 1'b0;
          done[c] <= 1'b0;
        end else if (en[c]) begin
          if (rem[c] == '0) begin
            rem[c]  <= shadow_div[c];
            tick[c] <= 1'b1;
            sq[c]   <= ~sq[c];
            if (oneshot[c]) begin
              en[c]   <= 1'b0;
              done[c] <= 1'b1;
            end
          end else begin
            rem[c] <= rem[c] - 1'b1;
          end
        end
        if (wr_ctl[c]) begin
          en[c]      <= iowdt[0];
          oneshot[c] <= iowdt[1];
          if (iowdt[0]) done[c] <= 1'b0;
        end
        if (wr_lo[c]) shadow_div[c][15:0]    <= iowdt;
        if (wr_hi[c]) shadow_div[c][CW-1:16] <= iowdt[HW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi: reset/idle vector table, directed corner
// sequences, then random bus traffic against a cycle-level behavioural model.
module tb_tick_gen_multi;
  localparam int         NCH     = 4;
  localparam int         CW      = 28;
  localparam logic [7:0] IOBASE  = 8'hE0;
  localparam int         DEF_DIV = 2;

  logic           clk50 = 1'b0;
  logic           reset, iow, ior;
  logic [7:0]     ioad;
  logic [15:0]    iowdt;
  logic [15:0]    iordt;
  logic [NCH-1:0] tick, sq, done;

  always #5 clk50 = ~clk50;

  tick_gen_multi #(
    .NCH(NCH), .CW(CW), .IOBASE(IOBASE), .DEF_DIV(DEF_DIV), .DEF_EN(1'b1)
  ) dut (
    .clk50(clk50), .reset(reset), .ioad(ioad), .iowdt(iowdt), .iow(iow), .ior(ior),
    .iordt(iordt), .tick(tick), .sq(sq), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model: up-counter compared against the active divisor
  logic [CW-1:0]  m_shadow [NCH];
  logic [CW-1:0]  m_active [NCH];
  logic [CW-1:0]  m_cnt    [NCH];
  logic [NCH-1:0] m_en, m_os, m_sq, m_done, m_tick;
  logic [15:0]    m_iordt;

  function automatic bit decode(input logic [7:0] a, output int ch, output int off);
    int rel;
    rel = int'(a) - int'(IOBASE);
    ch  = (rel >= 0) ? rel / 4 : 0;
    off = (rel >= 0) ? rel % 4 : 0;
    return (rel >= 0) && (rel < 4 * NCH);
  endfunction

  task automatic model_update();
    int ch, off;
    bit hit, wr_here;
    logic [15:0] rdv;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_shadow[c] = CW'(DEF_DIV);
        m_active[c] = CW'(DEF_DIV);
        m_cnt[c]    = '0;
      end
      m_en = '1; m_os = '0; m_sq = '0; m_done = '0; m_tick = '0; m_iordt = '0;
      return;
    end
    hit = decode(ioad, ch, off);
    rdv = '0;
    if (ior && hit) begin
      case (off)
        0:       rdv = m_shadow[ch][15:0];
        1:       rdv = 16'(m_shadow[ch] >> 16);
        2:       rdv = {14'd0, m_os[ch], m_en[ch]};
        default: rdv = {13'd0, m_sq[ch], m_done[ch], m_en[ch]};
      endcase
    end
    m_iordt = rdv;
    for (int c = 0; c < NCH; c++) begin
      wr_here   = iow && hit && (ch == c);
      m_tick[c] = 1'b0;
      if (wr_here && off == 2 && iowdt[2]) begin
        m_cnt[c] = '0; m_active[c] = m_shadow[c]; m_sq[c] = 1'b0; m_done[c] = 1'b0;
      end else if (m_en[c]) begin
        if (m_cnt[c] == m_active[c]) begin
          m_cnt[c] = '0; m_active[c] = m_shadow[c];
          m_tick[c] = 1'b1; m_sq[c] = ~m_sq[c];
          if (m_os[c]) begin m_en[c] = 1'b0; m_done[c] = 1'b1; end
        end else begin
          m_cnt[c] = m_cnt[c] + 1'b1;
        end
      end
      if (wr_here && off == 2) begin
        m_en[c] = iowdt[0]; m_os[c] = iowdt[1];
        if (iowdt[0]) m_done[c] = 1'b0;
      end
      if (wr_here && off == 0) m_shadow[c][15:0] = iowdt;
      if (wr_here && off == 1) m_shadow[c] = {iowdt[CW-17:0], m_shadow[c][15:0]};
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk50);
    #1;
  endtask

  task automatic step_chk();
    step();
    check("model", 64'({tick, sq, done, iordt}), 64'({m_tick, m_sq, m_done, m_iordt}));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_chk();
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    iow = 1'b1; ioad = a; iowdt = d;
    step_chk();
    iow = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    ior = 1'b1; ioad = a;
    step_chk();
    ior = 1'b0;
  endtask

  typedef struct {
    logic           iow, ior;
    logic [7:0]     ad;
    logic [15:0]    wd;
    logic [NCH-1:0] e_tick, e_sq;
    logic [15:0]    e_iordt;
  } vec_t;

  vec_t tv [10];

  initial begin
    int first, cnt, r, ch, off;
    logic [NCH-1:0] sq_hold;
    bit paused_ok;

    // DEF_DIV=2: tick after every 3rd edge out of reset, sq flips with each tick
    tv[0] = '{1'b0, 1'b0, 8'h00, 16'h0, 4'h0, 4'h0, 16'h0000};
    tv[1] = '{1'b0, 1'b1, 8'hE3, 16'h0, 4'h0, 4'h0, 16'h0001};
    tv[2] = '{1'b0, 1'b0, 8'h00, 16'h0, 4'hF, 4'hF, 16'h0000};
    tv[3] = '{1'b0, 1'b1, 8'hE3, 16'h0, 4'h0, 4'hF, 16'h0005};
    tv[4] = '{1'b0, 1'b1, 8'hE0, 16'h0, 4'h0, 4'hF, 16'h0002};
    tv[5] = '{1'b0, 1'b1, 8'hE1, 16'h0, 4'hF, 4'h0, 16'h0000};
    tv[6] = '{1'b0, 1'b1, 8'hEE, 16'h0, 4'h0, 4'h0, 16'h0001};
    tv[7] = '{1'b0, 1'b1, 8'hD0, 16'h0, 4'h0, 4'h0, 16'h0000};
    tv[8] = '{1'b0, 1'b1, 8'hF0, 16'h0, 4'hF, 4'hF, 16'h0000};
    tv[9] = '{1'b0, 1'b1, 8'hDF, 16'h0, 4'h0, 4'hF, 16'h0000};

    reset = 1'b1; iow = 1'b0; ior = 1'b0; ioad = '0; iowdt = '0;
    step(); step();
    check("reset_state", 64'({tick, sq, done, iordt}), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      iow = tv[i].iow; ior = tv[i].ior; ioad = tv[i].ad; iowdt = tv[i].wd;
      step();
      check($sformatf("vec%0d", i), 64'({tick, sq, done, iordt}),
            64'({tv[i].e_tick, tv[i].e_sq, 4'h0, tv[i].e_iordt}));
    end
    iow = 1'b0; ior = 1'b0;

    // ch1 one-shot, div 4: single tick 5 edges after the restart write
    wr(8'hE4, 16'd4); wr(8'hE5, 16'd0); wr(8'hE6, 16'h3); wr(8'hE6, 16'h7);
    first = -1; cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      idle(1);
      if (tick[1]) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    check("t2_first_tick", 64'(first), 64'(5));
    check("t2_tick_count", 64'(cnt), 64'(1));
    check("t2_done", 64'(done[1]), 64'(1));
    rd(8'hE7);
    check("t2_status", 64'(iordt), 64'(16'h0006));

    // ch0 div 9, rewritten to 3 at cnt=5: ticks at edges 10,14,18,22 after restart
    wr(8'hE0, 16'd9); wr(8'hE1, 16'd0); wr(8'hE2, 16'h5);
    for (int k = 1; k <= 22; k++) begin
      if (k == 6) wr(8'hE0, 16'd3);
      else idle(1);
      check($sformatf("t3_tick_k%0d", k), 64'(tick[0]),
            64'(k == 10 || k == 14 || k == 18 || k == 22));
    end

    // restart lands in the terminal-count cycle: no tick, sq cleared, next tick 4 edges on
    idle(3);
    wr(8'hE2, 16'h5);
    check("t4_no_tick", 64'(tick[0]), 64'(0));
    check("t4_sq", 64'(sq[0]), 64'(0));
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      check($sformatf("t4_tick_k%0d", k), 64'(tick[0]), 64'(k == 4));
    end

    // ch2 paused at cnt=7 for 20 cycles; 13 more counts + terminal after resume
    wr(8'hE8, 16'd20); wr(8'hE9, 16'd0); wr(8'hEA, 16'h5);
    idle(6);
    wr(8'hEA, 16'h0);
    sq_hold = sq; paused_ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      idle(1);
      if (tick[2] || sq[2] != sq_hold[2]) paused_ok = 1'b0;
    end
    check("t5_paused", 64'(paused_ok), 64'(1));
    wr(8'hEA, 16'h1);
    first = -1;
    for (int k = 1; k <= 25; k++) begin
      idle(1);
      if (tick[2] && first < 0) first = k;
    end
    check("t5_resume_tick", 64'(first), 64'(14));

    // ch3: tick once (sq=1), arm one-shot without restart; next tick leaves sq=0, done=1
    wr(8'hEC, 16'd2); wr(8'hED, 16'd0); wr(8'hEE, 16'h5);
    idle(3);
    check("t6_first_tick", 64'({tick[3], sq[3]}), 64'(2'b11));
    wr(8'hEE, 16'h3);
    idle(2);
    check("t6_oneshot_tick", 64'({tick[3], sq[3], done[3]}), 64'(3'b101));
    idle(3);
    rd(8'hEF);
    check("t6_status", 64'(iordt), 64'(16'h0002));
    idle(1);
    check("t6_iordt_clear", 64'(iordt), 64'(0));

    idle(2);
    reset = 1'b1; ior = 1'b1; ioad = 8'hEF;
    step_chk();
    check("reset_mid", 64'({tick, sq, done, iordt}), 64'(0));
    reset = 1'b0; ior = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      iow = 1'b0; ior = 1'b0; reset = 1'b0;
      if (r < 2) begin
        reset = 1'b1;
      end else if (r < 32) begin
        ch  = $urandom_range(0, NCH - 1);
        off = $urandom_range(0, 3);
        iow = 1'b1;
        ioad = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8'hDC, 8'hF3))
                                             : 8'(int'(IOBASE) + 4 * ch + off);
        case (off)
          0: iowdt = 16'($urandom_range(0, 12));
          1: iowdt = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h0;
          2: iowdt = 16'($urandom_range(0, 7));
          default: iowdt = 16'($urandom);
        endcase
        ior = ($urandom_range(0, 9) == 0);
      end else if (r < 57) begin
        ior  = 1'b1;
        ioad = 8'($urandom_range(8'hDC, 8'hF3));
      end
      step_chk();
    end
    iow = 1'b0; ior = 1'b0; reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
